// File: rtl/gcd_pkg.sv
// Shared types for the GCD client/engine interface: result struct, client FSM states,
// and the default operand width.
package gcd_pkg;

  localparam int GCD_DATA_WIDTH = 8;

  typedef struct packed {
    logic [GCD_DATA_WIDTH-1:0] a;
    logic [GCD_DATA_WIDTH-1:0] b;
  } gcd_data;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER
  } state_e;

endpackage

// File: rtl/gcd_client_timer.sv
// Wait-state counter: clears on request handshake, counts while enabled and parks at its
// terminal count (TIMEOUT_CYCLES-1) so it can never wrap.
module gcd_client_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] r_count;
  logic          w_tc;

  assign w_tc = (r_count == TW'(TIMEOUT_CYCLES - 1));
  assign tc_o = w_tc;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/gcd_client.sv
// Requester side of the GCD engine interface: one request in flight, bounded wait, result echo.
// Optional build macro GCD_CLIENT_ZERO_BYPASS_EN answers zero-operand commands locally.
module gcd_client
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH     = GCD_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] cmd_a_i,
  input  logic [DATA_WIDTH-1:0] cmd_b_i,
  output logic                  eng_req_valid_o,
  input  logic                  eng_req_ready_i,
  output logic [DATA_WIDTH-1:0] eng_operand_a_o,
  output logic [DATA_WIDTH-1:0] eng_operand_b_o,
  input  logic                  eng_resp_valid_i,
  input  gcd_data               eng_gcd_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_gcd_o,
  output logic [DATA_WIDTH-1:0] res_a_o,
  output logic [DATA_WIDTH-1:0] res_b_o,
  output logic                  res_err_o,
  output logic                  busy_o
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_gcd;
  logic                  r_err;

  logic                  w_load_cmd;
  logic                  w_load_res;
  logic [DATA_WIDTH-1:0] w_gcd_nxt;
  logic                  w_err_nxt;
  logic                  w_timer_clr;
  logic                  w_timer_en;
  logic                  w_timer_tc;
  logic [DATA_WIDTH-1:0] w_eng_gcd;
  logic                  w_unused_eng_b;

  assign w_eng_gcd      = DATA_WIDTH'(eng_gcd_i.a);
  assign w_unused_eng_b = ^eng_gcd_i.b;

  assign w_timer_clr = (r_state == S_ISSUE) && eng_req_ready_i;
  assign w_timer_en  = (r_state == S_WAIT);

  gcd_client_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .clr_i    (w_timer_clr),
    .en_i     (w_timer_en),
    .tc_o     (w_timer_tc)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_cmd  = 1'b0;
    w_load_res  = 1'b0;
    w_gcd_nxt   = '0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_load_cmd  = 1'b1;
`ifdef GCD_CLIENT_ZERO_BYPASS_EN
          // gcd(x,0) == x, so a zero operand never needs the engine
          if ((cmd_a_i == '0) || (cmd_b_i == '0)) begin
            w_state_nxt = S_DELIVER;
            w_load_res  = 1'b1;
            w_gcd_nxt   = cmd_a_i | cmd_b_i;
          end else begin
            w_state_nxt = S_ISSUE;
          end
`else
          w_state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (eng_req_ready_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the terminal-count cycle still counts as success
        if (eng_resp_valid_i) begin
          w_state_nxt = S_DELIVER;
          w_load_res  = 1'b1;
          w_gcd_nxt   = w_eng_gcd;
        end else if (w_timer_tc) begin
          w_state_nxt = S_DELIVER;
          w_load_res  = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end
      S_DELIVER: begin
        if (res_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_gcd <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_load_cmd) begin
        r_a <= cmd_a_i;
        r_b <= cmd_b_i;
      end
      if (w_load_res) begin
        r_gcd <= w_gcd_nxt;
        r_err <= w_err_nxt;
      end
    end
  end

  assign cmd_ready_o     = (r_state == S_IDLE);
  assign eng_req_valid_o = (r_state == S_ISSUE);
  assign eng_operand_a_o = r_a;
  assign eng_operand_b_o = r_b;
  assign res_valid_o     = (r_state == S_DELIVER);
  assign res_gcd_o       = r_gcd;
  assign res_a_o         = r_a;
  assign res_b_o         = r_b;
  assign res_err_o       = r_err;
  assign busy_o          = (r_state != S_IDLE);

endmodule
